// File: rtl/stc_sequencer_if.sv
// Bus between the radar timing controller and the STC sequencer: trigger,
// breakpoint-table configuration and the per-sample gain outputs.
interface stc_sequencer_if;
  logic        trig;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [11:0] cfg_idx;
  logic [11:0] cfg_gain;
  logic        cfg_len_we;
  logic [4:0]  cfg_len;
  logic [11:0] shift_ctrl;
  logic [11:0] sample_count;
  logic        sample_stb;
  logic        sweep_active;
  logic        overrun;
  logic        cfg_err;

  modport master (
    output trig, cfg_we, cfg_addr, cfg_idx, cfg_gain, cfg_len_we, cfg_len,
    input  shift_ctrl, sample_count, sample_stb, sweep_active, overrun, cfg_err
  );

  modport slave (
    input  trig, cfg_we, cfg_addr, cfg_idx, cfg_gain, cfg_len_we, cfg_len,
    output shift_ctrl, sample_count, sample_stb, sweep_active, overrun, cfg_err
  );
endinterface

// File: rtl/stc_sequencer.sv
// Sensitivity-time-control sequencer: walks a breakpoint table of gain codes
// across a radar sweep, one sample index every SAMPLE_DIV clocks.
module stc_sequencer #(
  parameter logic [11:0] SAMPLE_LIMIT = 12'd2626,
  parameter int          SAMPLE_DIV   = 1,
  parameter logic [11:0] UNITY_GAIN   = 12'h800
) (
  input logic            clk,
  input logic            rst,
  stc_sequencer_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} stateT;

  localparam logic [11:0] DIV_LAST = 12'(SAMPLE_DIV - 1);

  stateT       state;
  stateT       stateNext;
  logic        trigReg;
  logic [11:0] tblIdx  [16];
  logic [11:0] tblGain [16];
  logic [4:0]  tblLen;
  logic [4:0]  ptr;
  logic [11:0] divCnt;
  logic [11:0] shiftCtrl;
  logic [11:0] sampleCount;
  logic        sampleStb;
  logic        overrun;
  logic        cfgErr;

  logic        trigEdge;
  logic        cfgWrite;
  logic        divExpire;
  logic        lastSample;
  logic        entryHit;
  logic        startSweep;
  logic        endSweep;
  logic [4:0]  lenClamped;
  logic [4:0]  lenEffective;

  assign trigEdge     = bus.trig & ~trigReg;
  assign cfgWrite     = bus.cfg_we | bus.cfg_len_we;
  assign lenClamped   = (bus.cfg_len > 5'd16) ? 5'd16 : bus.cfg_len;
  // A length write landing with the trigger edge decides whether the sweep starts.
  assign lenEffective = bus.cfg_len_we ? lenClamped : tblLen;
  assign divExpire    = (divCnt == DIV_LAST);
  assign lastSample   = (sampleCount == SAMPLE_LIMIT);
  assign entryHit     = sampleStb && (ptr < tblLen) && (sampleCount == tblIdx[ptr[3:0]]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    startSweep = 1'b0;
    endSweep   = 1'b0;
    case (state)
      IDLE: begin
        if (trigEdge && (lenEffective != 5'd0)) begin
          stateNext  = SWEEP;
          startSweep = 1'b1;
        end
      end
      SWEEP: begin
        if (divExpire && lastSample) begin
          stateNext = IDLE;
          endSweep  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The table is frozen for the whole sweep so the pointer walk stays coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        tblIdx[i]  <= '0;
        tblGain[i] <= '0;
      end
      tblLen <= '0;
    end else if (state == IDLE) begin
      if (bus.cfg_we) begin
        tblIdx[bus.cfg_addr]  <= bus.cfg_idx;
        tblGain[bus.cfg_addr] <= bus.cfg_gain;
      end
      if (bus.cfg_len_we) begin
        tblLen <= lenClamped;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shiftCtrl   <= UNITY_GAIN;
      sampleCount <= SAMPLE_LIMIT;
      sampleStb   <= 1'b0;
      ptr         <= '0;
      divCnt      <= '0;
    end else if (startSweep) begin
      sampleCount <= '0;
      sampleStb   <= 1'b1;
      ptr         <= '0;
      divCnt      <= '0;
    end else if (endSweep) begin
      // Termination outranks a breakpoint hit on the final sample.
      shiftCtrl <= UNITY_GAIN;
      sampleStb <= 1'b0;
      divCnt    <= '0;
    end else if (state == SWEEP) begin
      if (entryHit) begin
        shiftCtrl <= tblGain[ptr[3:0]];
        ptr       <= ptr + 5'd1;
      end
      if (divExpire) begin
        divCnt      <= '0;
        sampleCount <= sampleCount + 12'd1;
        sampleStb   <= 1'b1;
      end else begin
        divCnt    <= divCnt + 12'd1;
        sampleStb <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trigReg <= 1'b0;
      overrun <= 1'b0;
      cfgErr  <= 1'b0;
    end else begin
      trigReg <= bus.trig;
      overrun <= (state == SWEEP) && trigEdge;
      cfgErr  <= (state == SWEEP) && cfgWrite;
    end
  end

  assign bus.shift_ctrl   = shiftCtrl;
  assign bus.sample_count = sampleCount;
  assign bus.sample_stb   = sampleStb;
  assign bus.sweep_active = (state == SWEEP);
  assign bus.overrun      = overrun;
  assign bus.cfg_err      = cfgErr;

endmodule

// File: tb/tb_stc_sequencer.sv
// Bench for stc_sequencer: one- and four-clock-per-sample instances share stimulus
// and are compared each cycle against a precomputed sweep schedule.
module tb_stc_sequencer;

  localparam logic [11:0] LIMIT = 12'd2626;
  localparam logic [11:0] UNITY = 12'h800;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        trig     = 1'b0;
  logic        cfgWe    = 1'b0;
  logic [3:0]  cfgAddr  = '0;
  logic [11:0] cfgIdx   = '0;
  logic [11:0] cfgGain  = '0;
  logic        cfgLenWe = 1'b0;
  logic [4:0]  cfgLen   = '0;

  int checks = 0;
  int errors = 0;
  bit badSeen = 1'b0;

  stc_sequencer_if busA ();
  stc_sequencer_if busB ();

  assign busA.trig = trig;         assign busB.trig = trig;
  assign busA.cfg_we = cfgWe;      assign busB.cfg_we = cfgWe;
  assign busA.cfg_addr = cfgAddr;  assign busB.cfg_addr = cfgAddr;
  assign busA.cfg_idx = cfgIdx;    assign busB.cfg_idx = cfgIdx;
  assign busA.cfg_gain = cfgGain;  assign busB.cfg_gain = cfgGain;
  assign busA.cfg_len_we = cfgLenWe; assign busB.cfg_len_we = cfgLenWe;
  assign busA.cfg_len = cfgLen;    assign busB.cfg_len = cfgLen;

  stc_sequencer #(.SAMPLE_LIMIT(LIMIT), .SAMPLE_DIV(1), .UNITY_GAIN(UNITY)) dutA (
    .clk(clk), .rst(rst), .bus(busA.slave));
  stc_sequencer #(.SAMPLE_LIMIT(LIMIT), .SAMPLE_DIV(4), .UNITY_GAIN(UNITY)) dutB (
    .clk(clk), .rst(rst), .bus(busB.slave));

  always #5 clk = ~clk;

  // Model state: committed table per instance plus the gain schedule of the running sweep.
  logic [11:0] mIdx  [2][16];
  logic [11:0] mGain [2][16];
  int          mLen  [2];
  bit          mActive [2];
  int          mT   [2];
  int          mEnd [2];
  int          evCycle [2][16];
  logic [11:0] evGain  [2][16];
  int          nEv [2];
  bit          mTrigPrev [2];
  bit          mOverrun [2];
  bit          mCfgErr [2];

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic modelStep(input int k);
    bit edgeSeen;
    int d;
    int last;
    d = (k == 0) ? 1 : 4;
    edgeSeen = trig && !mTrigPrev[k];
    mOverrun[k] = 1'b0;
    mCfgErr[k]  = 1'b0;
    if (mActive[k]) begin
      mOverrun[k] = edgeSeen;
      mCfgErr[k]  = cfgWe || cfgLenWe;
      mT[k]++;
      if (mT[k] >= mEnd[k]) mActive[k] = 1'b0;
    end else begin
      if (cfgWe) begin
        mIdx[k][cfgAddr]  = cfgIdx;
        mGain[k][cfgAddr] = cfgGain;
      end
      if (cfgLenWe) mLen[k] = (cfgLen > 5'd16) ? 16 : int'(cfgLen);
      if (edgeSeen && mLen[k] > 0) begin
        mActive[k] = 1'b1;
        mT[k]      = 0;
        mEnd[k]    = (int'(LIMIT) + 1) * d;
        nEv[k]     = 0;
        last       = -1;
        // Samples ascend one at a time, so only a strictly rising idx chain can be reached.
        for (int p = 0; p < mLen[k]; p++) begin
          if (int'(mIdx[k][p]) > last && mIdx[k][p] <= LIMIT) begin
            evCycle[k][nEv[k]] = int'(mIdx[k][p]) * d + 1;
            evGain[k][nEv[k]]  = mGain[k][p];
            nEv[k]++;
            last = int'(mIdx[k][p]);
          end else begin
            break;
          end
        end
      end
    end
    mTrigPrev[k] = trig;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 16; i++) begin
          mIdx[k][i]  = '0;
          mGain[k][i] = '0;
        end
        mLen[k] = 0; mActive[k] = 1'b0; mT[k] = 0; mEnd[k] = 0; nEv[k] = 0;
        mTrigPrev[k] = 1'b0; mOverrun[k] = 1'b0; mCfgErr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) modelStep(k);
    end
  end

  function automatic logic [11:0] expShift(input int k);
    logic [11:0] g;
    g = UNITY;
    if (mActive[k]) begin
      for (int e = 0; e < nEv[k]; e++) if (evCycle[k][e] <= mT[k]) g = evGain[k][e];
    end
    return g;
  endfunction

  task automatic compareInst(input int k, input logic [11:0] sc, input logic [11:0] cnt,
                             input logic stb, input logic act, input logic ovr, input logic err);
    int d;
    d = (k == 0) ? 1 : 4;
    checkOutput("shift_ctrl", k, sc, expShift(k));
    checkOutput("sample_count", k, cnt, mActive[k] ? 32'(mT[k] / d) : 32'(LIMIT));
    checkOutput("sample_stb", k, stb, mActive[k] && (mT[k] % d == 0));
    checkOutput("sweep_active", k, act, mActive[k]);
    checkOutput("overrun", k, ovr, mOverrun[k]);
    checkOutput("cfg_err", k, err, mCfgErr[k]);
  endtask

  always @(negedge clk) begin
    compareInst(0, busA.shift_ctrl, busA.sample_count, busA.sample_stb, busA.sweep_active,
                busA.overrun, busA.cfg_err);
    compareInst(1, busB.shift_ctrl, busB.sample_count, busB.sample_stb, busB.sweep_active,
                busB.overrun, busB.cfg_err);
    if (busA.shift_ctrl == 12'h222 || busA.shift_ctrl == 12'h333) badSeen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic advance(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [11:0] idx,
                               input logic [11:0] gain, input logic lenWe,
                               input logic [4:0] len, input logic trg);
    cfgWe = we; cfgAddr = addr; cfgIdx = idx; cfgGain = gain;
    cfgLenWe = lenWe; cfgLen = len; trig = trg;
    tick();
    cfgWe = 1'b0; cfgLenWe = 1'b0; trig = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((busA.sweep_active || busB.sweep_active) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("sweepEndTimeout", 0, busA.sweep_active || busB.sweep_active, 0);
  endtask

  initial begin
    advance(3);
    @(negedge clk);
    checkOutput("rstShift", 0, busA.shift_ctrl, 12'h800);
    checkOutput("rstCount", 0, busA.sample_count, 12'd2626);
    checkOutput("rstActive", 1, busB.sweep_active, 0);
    tick();
    rst = 1'b1;
    tick();

    // Basic sweep: breakpoints at 0, 60, 2600.
    applyStimulus(1, 4'd0, 12'd0, 12'h001, 0, 5'd0, 0);
    applyStimulus(1, 4'd1, 12'd60, 12'h002, 0, 5'd0, 0);
    applyStimulus(1, 4'd2, 12'd2600, 12'h800, 0, 5'd0, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 1, 5'd3, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    @(negedge clk);
    checkOutput("startCount", 0, busA.sample_count, 0);
    checkOutput("startStb", 0, busA.sample_stb, 1);
    checkOutput("startActive", 1, busB.sweep_active, 1);
    advance(1); @(negedge clk);
    checkOutput("gainAt0", 0, busA.shift_ctrl, 12'h001);
    advance(60); @(negedge clk);
    checkOutput("gainAt60", 0, busA.shift_ctrl, 12'h002);
    advance(179); @(negedge clk);
    checkOutput("div4Count60", 1, busB.sample_count, 12'd60);
    checkOutput("div4Stb", 1, busB.sample_stb, 1);
    advance(1); @(negedge clk);
    checkOutput("div4GainAt241", 1, busB.shift_ctrl, 12'h002);
    advance(2385); @(negedge clk);
    checkOutput("lastSampleActive", 0, busA.sweep_active, 1);
    advance(1); @(negedge clk);
    checkOutput("sweepEndActive", 0, busA.sweep_active, 0);
    checkOutput("sweepEndCount", 0, busA.sample_count, 12'd2626);
    waitIdle(11000);

    // Zero length: trigger ignored without overrun.
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 1, 5'd0, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    advance(2); @(negedge clk);
    checkOutput("len0NoSweep", 0, busA.sweep_active, 0);
    checkOutput("len0Shift", 0, busA.shift_ctrl, 12'h800);

    // Non-ascending table, re-trigger at count 500, rejected write at count 700.
    applyStimulus(1, 4'd0, 12'd100, 12'h111, 0, 5'd0, 0);
    applyStimulus(1, 4'd1, 12'd50, 12'h222, 0, 5'd0, 0);
    applyStimulus(1, 4'd2, 12'd200, 12'h333, 0, 5'd0, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 1, 5'd3, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    advance(500);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    @(negedge clk);
    checkOutput("overrunPulse", 0, busA.overrun, 1);
    checkOutput("overrunPulse", 1, busB.overrun, 1);
    checkOutput("gainAt100", 0, busA.shift_ctrl, 12'h111);
    advance(199);
    applyStimulus(1, 4'd0, 12'd5, 12'h0ab, 0, 5'd0, 0);
    @(negedge clk);
    checkOutput("cfgErrPulse", 0, busA.cfg_err, 1);
    advance(1); @(negedge clk);
    checkOutput("cfgErrOnce", 0, busA.cfg_err, 0);
    waitIdle(11000);
    checkOutput("neverAppliedGain", 0, badSeen, 0);
    checkOutput("endForcesUnity", 1, busB.shift_ctrl, 12'h800);

    // Sixteen entries, length 17 written together with the trigger edge.
    for (int i = 1; i < 16; i++)
      applyStimulus(1, 4'(i), 12'(100 + i * 10), 12'(i + 1), 0, 5'd0, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 1, 5'd17, 1);
    @(negedge clk);
    checkOutput("len17Start", 0, busA.sweep_active, 1);
    advance(101); @(negedge clk);
    checkOutput("keptEntry0", 0, busA.shift_ctrl, 12'h111);
    advance(150); @(negedge clk);
    checkOutput("entry15Gain", 0, busA.shift_ctrl, 12'h010);
    waitIdle(11000);

    // Reset mid-sweep, then no sweep until the length is reprogrammed.
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    advance(1000); @(negedge clk);
    checkOutput("count1000", 0, busA.sample_count, 12'd1000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("asyncRstActive", 0, busA.sweep_active, 0);
    checkOutput("asyncRstCount", 0, busA.sample_count, 12'd2626);
    checkOutput("asyncRstShift", 1, busB.shift_ctrl, 12'h800);
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    advance(3); @(negedge clk);
    checkOutput("noSweepAfterRst", 0, busA.sweep_active, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 1, 5'd2, 0);
    applyStimulus(0, 4'd0, 12'd0, 12'h000, 0, 5'd0, 1);
    @(negedge clk);
    checkOutput("restartActive", 0, busA.sweep_active, 1);
    advance(1); @(negedge clk);
    checkOutput("clearedTableGain", 0, busA.shift_ctrl, 12'h000);
    advance(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stc_sequencer.md
STC_SEQUENCER -- requirements
Module: stc_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_LIMIT, default 12'd2626, last sample index of a sweep.
REQ-002 SHALL have parameter SAMPLE_DIV, default 1, clk cycles per sample (legal range 1..4095).
REQ-003 SHALL have parameter UNITY_GAIN, default 12'h800, shift_ctrl code for gain 1.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 trig  input  1  radar trigger, clk-synchronous; a sweep starts on a rising edge.
REQ-007 cfg_we  input  1  table entry write strobe.
REQ-008 cfg_addr  input  4  table entry address 0..15.
REQ-009 cfg_idx  input  12  breakpoint sample index for the entry.
REQ-010 cfg_gain  input  12  shift_ctrl code for the entry.
REQ-011 cfg_len_we  input  1  table length write strobe.
REQ-012 cfg_len  input  5  number of valid entries, 0..16.
REQ-013 shift_ctrl  output  12  registered gain code for the STC shift/add datapath.
REQ-014 sample_count  output  12  registered current sample index.
REQ-015 sample_stb  output  1  one-cycle pulse marking a new sample_count value.
REQ-016 sweep_active  output  1  high while in SWEEP.
REQ-017 overrun  output  1  one-cycle pulse: trigger rising edge ignored during a sweep.
REQ-018 cfg_err  output  1  one-cycle pulse: config write rejected during a sweep.

Function
REQ-019 SHALL hold a 16-entry table {idx[11:0], gain[11:0]} and a 5-bit length register; cfg_len values above 16 SHALL be stored as 16.
REQ-020 SHALL commit table and length writes at the clock edge if state is IDLE; writes in SWEEP SHALL be dropped and cfg_err SHALL pulse on the following cycle.
REQ-021 SHALL detect a trigger edge as trig=1 with trig registered 0 on the previous cycle.
REQ-022 State machine SHALL have two states, IDLE and SWEEP.
REQ-023 IDLE->SWEEP on a trigger edge with length>0; a trigger edge with length=0 SHALL be ignored, with no overrun.
REQ-024 On entering SWEEP: sample_count=0, entry pointer=0, divider=0, sample_stb=1, and sweep_active=1, all in the first SWEEP cycle.
REQ-025 In SWEEP, sample_count SHALL increment by 1 every SAMPLE_DIV clocks, and sample_stb SHALL pulse in the cycle each new value first appears.
REQ-026 On a sample_stb cycle with pointer<length and sample_count==table[pointer].idx: shift_ctrl<=table[pointer].gain and pointer increments, so latency is 1 clk from the strobe.
REQ-027 The pointer SHALL advance only on an exact match, with at most one entry per sample. A non-ascending or duplicate idx therefore stalls all later entries for the rest of the sweep (defined, not an error).
REQ-028 When sample_count==SAMPLE_LIMIT and the divider expires: SWEEP->IDLE, sweep_active=0, shift_ctrl=UNITY_GAIN, sample_count holds SAMPLE_LIMIT.
REQ-029 In IDLE, shift_ctrl SHALL hold UNITY_GAIN and sample_stb SHALL be 0.
REQ-030 A trigger edge in SWEEP SHALL be ignored, the sweep SHALL continue unchanged, and overrun SHALL pulse on the following cycle.
REQ-031 A trigger edge in the same cycle as sweep termination SHALL be treated as overrun and SHALL NOT restart the sweep.
REQ-032 A config write in IDLE in the same cycle as a trigger edge SHALL commit, and the sweep SHALL use the updated table.

Reset
REQ-033 rst low SHALL asynchronously force IDLE, shift_ctrl=UNITY_GAIN, sample_count=SAMPLE_LIMIT, sample_stb=0, sweep_active=0, overrun=0, cfg_err=0, pointer=0, length=0, all table entries=0, and trig register=0.
REQ-034 Reset asserted mid-sweep SHALL abort the sweep immediately, and no sweep SHALL start until a new trigger edge after rst is released and the table length is reprogrammed.

Verification
REQ-035 Table {0:000001, 60:000010, 2600:800}, len=3, SAMPLE_DIV=1, trig pulse -> shift_ctrl=12'h001 one clk after count 0, 12'h002 one clk after count 60, 12'h800 one clk after count 2600; sweep_active drops after count 2626.
REQ-036 SAMPLE_DIV=4, same table -> sample_stb every 4 clks; the count-60 update occurs 241 clks after sweep start.
REQ-037 Table idx order {100, 50, 200}, len=3 -> gain for 100 applied; 50 and 200 never applied; end-of-sweep forces 12'h800.
REQ-038 Second trig rising edge at count 500 plus a cfg_we at count 700 -> overrun and cfg_err each pulse once, the table is unchanged, and the sweep completes normally.
REQ-039 len=0 with a trig pulse -> no sweep, no overrun, shift_ctrl stays 12'h800; then len=17 -> length register reads back as 16 (via a 16-entry sweep).
REQ-040 rst low at count 1000 -> all outputs at reset values asynchronously; after release, a trig pulse starts no sweep until len is rewritten.
